// File: rtl/fifo_flush_drain.sv
// rtl/fifo_flush_drain.sv - flush-word reader that serializes the captured word into nibbles
// Optional trailing-pad strip: define FIFO_FLUSH_DRAIN_PAD_STRIP_EN.
module fifo_flush_drain #(
    parameter int               NIB_W        = 4,
    parameter int               NIBBLES      = 8,
    parameter logic [NIB_W-1:0] PAD_NIBBLE   = 4'hC,
    parameter int               FLUSH_CYCLES = 2,
    parameter int               TIMEOUT      = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     empty_i,
    output logic                     flush_o,
    input  logic                     word_valid_i,
    input  logic [NIB_W*NIBBLES-1:0] word_i,
    output logic                     nib_valid_o,
    output logic [NIB_W-1:0]         nib_data_o,
    input  logic                     nib_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [3:0]               nib_count_o
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [FW-1:0] flush_cnt;
    logic [TW-1:0] tcnt;
    logic [W-1:0]  word_q;
    logic [W-1:0]  word_shifted;
    logic [3:0]    idx;
    logic [3:0]    len_q;
    logic [3:0]    cap_len;
    logic          timeout_q;

`ifdef FIFO_FLUSH_DRAIN_PAD_STRIP_EN
    logic pad_run;

    // Walk down from the top slot; the first non-pad nibble ends the strippable run.
    always_comb begin
        cap_len = 4'(NIBBLES);
        pad_run = 1'b1;
        for (int k = NIBBLES - 1; k >= 0; k--) begin
            if (pad_run && word_i[k*NIB_W +: NIB_W] == PAD_NIBBLE) begin
                cap_len = cap_len - 4'd1;
            end else begin
                pad_run = 1'b0;
            end
        end
    end
`else
    assign cap_len = 4'(NIBBLES);
`endif

    assign word_shifted = word_q >> (NIB_W * idx);

    assign flush_o     = (state == REQ);
    assign nib_valid_o = (state == SHIFT);
    assign nib_data_o  = (state == SHIFT) ? word_shifted[NIB_W-1:0] : '0;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign timeout_o   = (state == DONE) && timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            tcnt        <= '0;
            word_q      <= '0;
            idx         <= '0;
            len_q       <= '0;
            timeout_q   <= 1'b0;
            nib_count_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (start_i) begin
                        nib_count_o <= '0;
                        idx         <= '0;
                        tcnt        <= '0;
                        flush_cnt   <= FW'(FLUSH_CYCLES);
                        state       <= empty_i ? DONE : REQ;
                    end
                end
                REQ, WAIT: begin
                    if (word_valid_i) begin
                        // A returned word wins over both the flush count and the timeout.
                        word_q <= word_i;
                        len_q  <= cap_len;
                        idx    <= '0;
                        state  <= (cap_len == 4'd0) ? DONE : SHIFT;
                    end else if (state == REQ) begin
                        if (flush_cnt <= FW'(1)) begin
                            tcnt  <= '0;
                            state <= WAIT;
                        end else begin
                            flush_cnt <= flush_cnt - 1'b1;
                        end
                    end else begin
                        if (tcnt != TW'(TIMEOUT)) begin
                            tcnt <= tcnt + 1'b1;
                        end
                        if (tcnt >= TW'(TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (nib_ready_i) begin
                        if (idx != 4'hF) begin
                            idx <= idx + 4'd1;
                        end
                        if (nib_count_o != 4'hF) begin
                            nib_count_o <= nib_count_o + 4'd1;
                        end
                        if (idx == len_q - 4'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
